alu_issue_buffer: RTL and testbench

Two-entry elastic issue buffer that sits directly upstream of the ALU in the EX stage. It accepts decoded operand bundles (two 32-bit sources, 4-bit ALU control, 5-bit destination register) from decode over a valid/ready handshake. It presents the oldest bundle to the ALU inputs, decoupling decode stalls from EX stalls without losing or duplicating an operation. It also flags control codes that the ALU does not implement.

---
 rtl/alu_issue_buffer.sv | 101 ++++++++++
 tb/tb_alu_issue_buffer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_buffer.sv
// Two-entry elastic issue buffer in front of the EX-stage ALU.
// Holds decoded operand bundles in strict FIFO order and flags control codes the ALU does not implement.
module alu_issue_buffer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_src1_i,
    input  logic [31:0] in_src2_i,
    input  logic [3:0]  in_ctrl_i,
    input  logic [4:0]  in_rd_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] src1_o,
    output logic [31:0] src2_o,
    output logic [3:0]  ctrl_o,
    output logic [4:0]  rd_o,
    output logic        illegal_o,
    output logic [1:0]  count_o
);

    localparam int DEPTH = 2;

    logic [31:0] slot_src1 [DEPTH];
    logic [31:0] slot_src2 [DEPTH];
    logic [3:0]  slot_ctrl [DEPTH];
    logic [4:0]  slot_rd   [DEPTH];

    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;
    logic       not_empty;

    // Ready looks only at registered occupancy and reset, keeping EX stalls off the decode path.
    assign not_empty   = (count != 2'd0);
    assign in_ready_o  = (count != 2'd2) & rst_i;
    assign out_valid_o = not_empty;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign count_o     = count;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (flush_i) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Slot storage needs no reset; occupancy decides what is visible.
    always_ff @(posedge clk_i) begin
        if (rst_i && !flush_i && push) begin
            slot_src1[wr_ptr] <= in_src1_i;
            slot_src2[wr_ptr] <= in_src2_i;
            slot_ctrl[wr_ptr] <= in_ctrl_i;
            slot_rd[wr_ptr]   <= in_rd_i;
        end
    end

    always_comb begin
        src1_o = 32'd0;
        src2_o = 32'd0;
        ctrl_o = 4'd0;
        rd_o   = 5'd0;
        if (not_empty) begin
            src1_o = slot_src1[rd_ptr];
            src2_o = slot_src2[rd_ptr];
            ctrl_o = slot_ctrl[rd_ptr];
            rd_o   = slot_rd[rd_ptr];
        end
    end

    // Unimplemented codes are still delivered; the flag only tells EX to trap.
    always_comb begin
        case (ctrl_o)
            4'd0, 4'd1, 4'd2, 4'd6, 4'd7,
            4'd8, 4'd9, 4'd10, 4'd12: illegal_o = 1'b0;
            default:                  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_alu_issue_buffer.sv
// Self-checking bench for alu_issue_buffer: directed scenarios then random traffic,
// compared each cycle against a queue-based reference model.
module tb_alu_issue_buffer;

    logic        clk_i;
    logic        rst_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_src1_i;
    logic [31:0] in_src2_i;
    logic [3:0]  in_ctrl_i;
    logic [4:0]  in_rd_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] src1_o;
    logic [31:0] src2_o;
    logic [3:0]  ctrl_o;
    logic [4:0]  rd_o;
    logic        illegal_o;
    logic [1:0]  count_o;

    typedef struct packed {
        logic [31:0] s1;
        logic [31:0] s2;
        logic [3:0]  c;
        logic [4:0]  rd;
    } bundle_t;

    bundle_t model_q[$];
    int compared;
    int mismatched;
    int delivered;

    alu_issue_buffer dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_src1_i   (in_src1_i),
        .in_src2_i   (in_src2_i),
        .in_ctrl_i   (in_ctrl_i),
        .in_rd_i     (in_rd_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .src1_o      (src1_o),
        .src2_o      (src2_o),
        .ctrl_o      (ctrl_o),
        .rd_o        (rd_o),
        .illegal_o   (illegal_o),
        .count_o     (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic implemented(input logic [3:0] c);
        return c inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12};
    endfunction

    // Compare every DUT output with what the model's queue says should be visible.
    task automatic checkOutput();
        bundle_t head;
        int n;
        n = model_q.size();
        head = '0;
        if (n != 0) head = model_q[0];
        chk("count", 32'(count_o), 32'(n));
        chk("out_valid", 32'(out_valid_o), 32'(n != 0));
        chk("in_ready", 32'(in_ready_o), 32'((n < 2) && (rst_i === 1'b1)));
        chk("src1", src1_o, head.s1);
        chk("src2", src2_o, head.s2);
        chk("ctrl", 32'(ctrl_o), 32'(head.c));
        chk("rd", 32'(rd_o), 32'(head.rd));
        chk("illegal", 32'(illegal_o), 32'((n != 0) && !implemented(head.c)));
    endtask

    // Drive one cycle of inputs, check, clock, then advance the model by the handshake rules.
    task automatic applyStimulus(input logic v, input logic [31:0] s1, input logic [31:0] s2,
                                 input logic [3:0] c, input logic [4:0] rd,
                                 input logic ordy, input logic fl, input logic rst);
        bundle_t b;
        int n;
        logic acc;
        logic take;
        rst_i       = rst;
        flush_i     = fl;
        in_valid_i  = v;
        in_src1_i   = s1;
        in_src2_i   = s2;
        in_ctrl_i   = c;
        in_rd_i     = rd;
        out_ready_i = ordy;
        #1;
        checkOutput();
        @(posedge clk_i);
        b = '{s1: s1, s2: s2, c: c, rd: rd};
        n = model_q.size();
        acc = v && rst && (n < 2);
        take = rst && (n > 0) && ordy;
        if (take) delivered++;
        if (!rst || fl) begin
            model_q.delete();
        end else begin
            if (take) void'(model_q.pop_front());
            if (acc) model_q.push_back(b);
        end
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        delivered  = 0;

        // Reset held two cycles with a bundle offered.
        rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b0;
        in_src1_i = 32'hDEAD; in_src2_i = 32'hBEEF; in_ctrl_i = 4'd3; in_rd_i = 5'd7;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput();
        rst_i = 1'b1; in_valid_i = 1'b0;
        #1;
        chk("ready_after_release", 32'(in_ready_o), 32'd1);

        // Single pass.
        applyStimulus(1, 5, 3, 6, 4, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);

        // Fill with backpressure, C refused, then drain in order.
        applyStimulus(1, 32'hA, 32'h1A, 1, 1, 0, 0, 1);
        applyStimulus(1, 32'hB, 32'h1B, 2, 2, 0, 0, 1);
        applyStimulus(1, 32'hC, 32'h1C, 7, 3, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);

        // Streaming eight bundles back-to-back.
        for (int i = 0; i < 8; i++)
            applyStimulus(1, 32'(100 + i), 32'(200 + i), 4'(i % 3), 5'(i), 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);

        // Flush while full with a push and a pop offered.
        applyStimulus(1, 32'h11, 32'h21, 8, 9, 0, 0, 1);
        applyStimulus(1, 32'h12, 32'h22, 9, 10, 0, 0, 1);
        applyStimulus(1, 32'h13, 32'h23, 10, 11, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);

        // Illegal codes are flagged but still delivered.
        applyStimulus(1, 32'h40, 0, 4, 1, 1, 0, 1);
        applyStimulus(1, 32'h41, 0, 15, 2, 1, 0, 1);
        applyStimulus(1, 32'h42, 0, 12, 3, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);

        // Reset in the middle of a transfer.
        applyStimulus(1, 32'h50, 0, 1, 1, 0, 0, 1);
        applyStimulus(1, 32'h51, 0, 2, 2, 0, 0, 1);
        applyStimulus(1, 32'h52, 0, 6, 3, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            applyStimulus(1'($urandom_range(0, 99) < 60), $urandom, $urandom,
                          4'($urandom), 5'($urandom),
                          1'($urandom_range(0, 99) < 55),
                          1'($urandom_range(0, 99) < 4),
                          1'($urandom_range(0, 99) >= 2));
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);

        $display("[TB] bundles delivered: %0d", delivered);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
